sha_finalize_stage: RTL and testbench
=====================================

Name: sha_finalize_stage

Overview:
Sits directly downstream of the last round stage of the super-pipelined SHA-256 core and consumes its HashState, valid and newblock outputs.
- Adds the per-block chaining value to the post-round state to form the digest, in a configurable register pipeline.
- Tags each digest with a running nonce index.
- Tests each digest against a leading-zero difficulty target and captures the first hit in a sticky, acknowledged hit register.

Parameters:
ADD_PIPELINE_DEPTH, 1, register stages in the digest-add path; legal range 1..3.
ZERO_BITS, 32, leading digest bits (word a MSB first, then b, ...) that must be zero for a hit; legal range 1..64.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
state_i  input  HashState  post-round state from the last round stage.
chain_i  input  HashState  chaining value for the same block; sampled in the same cycle as state_i.
valid_i  input  1  state_i/chain_i qualify this cycle.
newblock_i  input  1  first block of a new job; meaningful only with valid_i.
digest_o  output  HashState  state_i + chain_i, word-wise.
valid_o  output  1  digest_o/nonce_o qualify.
newblock_o  output  1  delayed newblock_i.
nonce_o  output  32  index of the current digest within the job.
hit_valid_o  output  1  sticky: a hit is held.
hit_nonce_o  output  32  nonce of the held hit.
hit_digest_o  output  HashState  digest of the held hit.
hit_drop_o  output  1  sticky: a hit was lost because the hit register was full.
hit_ack_i  input  1  consumer releases the held hit.

Behaviour:
- Digest: each of the 8 words is state_i.x + chain_i.x mod 2^32 (carry out discarded). No cross-word carry.
- Latency: digest_o, valid_o and newblock_o appear exactly ADD_PIPELINE_DEPTH cycles after the matching input. One result per cycle, no stalls, no backpressure.
- Valid pipeline registers reset to 0, so valid_o=0 during and after reset. Data and newblock pipeline registers are not reset; digest_o and newblock_o are don't-care while valid_o=0.
- Nonce counter is a register that resets to 0. nonce_o is driven combinationally from it:
  - valid_o=1 with newblock_o=1: nonce_o=0 and counter <= 1.
  - valid_o=1 with newblock_o=0: nonce_o=counter and counter <= counter+1. Wraps 0xFFFFFFFF -> 0 silently.
  - valid_o=0: counter holds.
- Hit condition: valid_o=1 and the top ZERO_BITS bits of the 64-bit concatenation {digest_o.a, digest_o.b} are all zero. Evaluated combinationally on the output stage; no extra latency.
- Hit register states: EMPTY (hit_valid_o=0) and FULL (hit_valid_o=1).
  - EMPTY + hit: capture nonce_o and digest_o; go FULL next cycle.
  - FULL + hit_ack_i=1 + no hit: go EMPTY.
  - FULL + hit_ack_i=1 + hit in the same cycle: capture the new hit, stay FULL. The acked hit is consumed; no drop.
  - FULL + hit_ack_i=0 + hit: keep the old hit; set hit_drop_o.
  - hit_ack_i while EMPTY is ignored.
- hit_drop_o is cleared only by rst.
- Reset values: hit_valid_o=0, hit_drop_o=0, hit_nonce_o=0, hit_digest_o=0.
- Reset asserted mid-operation: all in-flight valids are killed immediately (asynchronous), any held hit is lost, and the counter returns to 0. No output marked valid_o=1 may appear for data accepted before reset.

Decomposition:
- Shared sha package: HashState typedef (already present); SHA-256 IV constants H0..H7; a HASH_WORDS=8 constant.
- Sub-module sha_state_adder_pipeline #(PIPELINE_DEPTH): 8 parallel 32-bit adders followed by PIPELINE_DEPTH data registers (non-reset ff).
- Valid delay uses rff (reset) flops; newblock delay uses ff (non-reset) flops, matching the round stage.

Test Plan:
- Zero state: state_i=0, chain_i=IV, valid_i=1, newblock_i=1 -> after ADD_PIPELINE_DEPTH cycles digest_o.a=0x6a09e667, digest_o.h=0x5be0cd19, nonce_o=0, newblock_o=1.
- Carry wrap: state_i all words=0xFFFFFFFF, chain_i all words=0x00000002 -> every digest word=0x00000001, with no carry into neighbouring words.
- Counter: newblock on the first of 5 back-to-back valids, then a bubble, then 2 more -> nonce_o 0,1,2,3,4,5,6. A new newblock restarts at 0. Force counter to 0xFFFFFFFF -> next nonce_o=0.
- Hit capture (ZERO_BITS=32): digest.a=0 at nonce 3 -> hit_valid_o=1 next cycle, hit_nonce_o=3. A second hit at nonce 5 without ack -> hit_nonce_o stays 3 and hit_drop_o=1.
- Ack collision: hit held; a new hit at nonce 9 in the same cycle as hit_ack_i=1 -> hit_nonce_o=9, hit_valid_o stays 1, hit_drop_o unchanged. A lone ack next -> hit_valid_o=0.
- Reset mid-flight: assert rst with 2 valids in the pipeline and a hit held -> valid_o=0 and hit_valid_o=0 immediately, no valid_o pulse after release, and the next newblock produces nonce_o=0.

Source files
------------

// File: rtl/sha_finalize_stage_pkg.sv
// Shared SHA-256 definitions for the finalize stage: state layout, IV and
// the hit-register state encoding.
package sha_finalize_stage_pkg;

  localparam int HASH_WORDS = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

  localparam HashState SHA256_IV = '{H0, H1, H2, H3, H4, H5, H6, H7};

  typedef enum logic {
    HIT_EMPTY = 1'b0,
    HIT_FULL  = 1'b1
  } hit_state_t;

  // True when the top zero_bits bits of the 64-bit word {a,b} are all zero.
  function automatic logic leading_zero_hit(input logic [63:0] top, input int zero_bits);
    return (top >> (64 - zero_bits)) == 64'd0;
  endfunction

endpackage

// File: rtl/sha_state_adder_pipeline.sv
// Word-wise chaining add (no cross-word carry) followed by PIPELINE_DEPTH
// non-reset data registers.
module sha_state_adder_pipeline
  import sha_finalize_stage_pkg::*;
#(
  parameter int PIPELINE_DEPTH = 1
) (
  input  logic     clk,
  input  HashState state,
  input  HashState chain,
  output HashState digest
);

  logic [32*HASH_WORDS-1:0] state_flat;
  logic [32*HASH_WORDS-1:0] chain_flat;
  logic [32*HASH_WORDS-1:0] sum_flat;
  HashState                 stage_reg [PIPELINE_DEPTH];

  assign state_flat = state;
  assign chain_flat = chain;

  generate
    for (genvar gi = 0; gi < HASH_WORDS; gi++) begin : g_word_add
      assign sum_flat[32*HASH_WORDS-1-32*gi -: 32] =
        state_flat[32*HASH_WORDS-1-32*gi -: 32] + chain_flat[32*HASH_WORDS-1-32*gi -: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    stage_reg[0] <= sum_flat;
    for (int i = 1; i < PIPELINE_DEPTH; i++) begin
      stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign digest = stage_reg[PIPELINE_DEPTH-1];

endmodule

// File: rtl/sha_finalize_stage.sv
// Final SHA-256 stage: digest add, nonce tagging and a sticky,
// acknowledged difficulty-hit register.
module sha_finalize_stage
  import sha_finalize_stage_pkg::*;
#(
  parameter int ADD_PIPELINE_DEPTH = 1,
  parameter int ZERO_BITS          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  HashState    state_i,
  input  HashState    chain_i,
  input  logic        valid_i,
  input  logic        newblock_i,
  output HashState    digest_o,
  output logic        valid_o,
  output logic        newblock_o,
  output logic [31:0] nonce_o,
  output logic        hit_valid_o,
  output logic [31:0] hit_nonce_o,
  output HashState    hit_digest_o,
  output logic        hit_drop_o,
  input  logic        hit_ack_i
);

  logic [ADD_PIPELINE_DEPTH-1:0] valid_pipe_reg;
  logic [ADD_PIPELINE_DEPTH-1:0] newblock_pipe_reg;
  logic [31:0]                   count_reg;
  hit_state_t                    hit_state_reg;
  hit_state_t                    hit_state_next;
  logic                          hit;
  logic                          capture;
  logic                          drop_set;
  logic [31:0]                   hit_nonce_reg;
  HashState                      hit_digest_reg;
  logic                          hit_drop_reg;

  sha_state_adder_pipeline #(
    .PIPELINE_DEPTH(ADD_PIPELINE_DEPTH)
  ) u_adder (
    .clk   (clk),
    .state (state_i),
    .chain (chain_i),
    .digest(digest_o)
  );

  // Valids are reset so a mid-flight reset kills every in-flight result.
  generate
    for (genvar gi = 0; gi < ADD_PIPELINE_DEPTH; gi++) begin : g_ctrl_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) valid_pipe_reg[gi] <= 1'b0;
          else     valid_pipe_reg[gi] <= valid_i;
        end
        always_ff @(posedge clk) newblock_pipe_reg[gi] <= newblock_i;
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) valid_pipe_reg[gi] <= 1'b0;
          else     valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
        end
        always_ff @(posedge clk) newblock_pipe_reg[gi] <= newblock_pipe_reg[gi-1];
      end
    end
  endgenerate

  assign valid_o    = valid_pipe_reg[ADD_PIPELINE_DEPTH-1];
  assign newblock_o = newblock_pipe_reg[ADD_PIPELINE_DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 32'd0;
    end else if (valid_o) begin
      count_reg <= newblock_o ? 32'd1 : count_reg + 32'd1;
    end
  end

  assign nonce_o = newblock_o ? 32'd0 : count_reg;
  assign hit     = valid_o && leading_zero_hit({digest_o.a, digest_o.b}, ZERO_BITS);

  always_comb begin
    hit_state_next = hit_state_reg;
    capture        = 1'b0;
    drop_set       = 1'b0;
    case (hit_state_reg)
      HIT_EMPTY: begin
        if (hit) begin
          capture        = 1'b1;
          hit_state_next = HIT_FULL;
        end
      end
      HIT_FULL: begin
        // An ack in the same cycle frees the slot for the incoming hit.
        if (hit_ack_i) begin
          if (hit) capture = 1'b1;
          else     hit_state_next = HIT_EMPTY;
        end else if (hit) begin
          drop_set = 1'b1;
        end
      end
      default: hit_state_next = HIT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_state_reg  <= HIT_EMPTY;
      hit_nonce_reg  <= 32'd0;
      hit_digest_reg <= '0;
      hit_drop_reg   <= 1'b0;
    end else begin
      hit_state_reg <= hit_state_next;
      if (capture) begin
        hit_nonce_reg  <= nonce_o;
        hit_digest_reg <= digest_o;
      end
      if (drop_set) hit_drop_reg <= 1'b1;
    end
  end

  assign hit_valid_o  = (hit_state_reg == HIT_FULL);
  assign hit_nonce_o  = hit_nonce_reg;
  assign hit_digest_o = hit_digest_reg;
  assign hit_drop_o   = hit_drop_reg;

endmodule

// File: tb/tb_sha_finalize_stage.sv
// Directed bench for sha_finalize_stage: table of single-shot digests plus
// streamed sequences for counter, hit, ack collision and reset corners.
module tb_sha_finalize_stage;
  import sha_finalize_stage_pkg::*;

  localparam int DEPTH = 2;
  localparam int ZB    = 32;

  logic        clk = 1'b0;
  logic        rst;
  HashState    state_i, chain_i;
  logic        valid_i, newblock_i, hit_ack_i;
  HashState    digest_o, hit_digest_o;
  logic        valid_o, newblock_o, hit_valid_o, hit_drop_o;
  logic [31:0] nonce_o, hit_nonce_o;

  int total = 0;
  int bad   = 0;

  sha_finalize_stage #(
    .ADD_PIPELINE_DEPTH(DEPTH),
    .ZERO_BITS         (ZB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .state_i     (state_i),
    .chain_i     (chain_i),
    .valid_i     (valid_i),
    .newblock_i  (newblock_i),
    .digest_o    (digest_o),
    .valid_o     (valid_o),
    .newblock_o  (newblock_o),
    .nonce_o     (nonce_o),
    .hit_valid_o (hit_valid_o),
    .hit_nonce_o (hit_nonce_o),
    .hit_digest_o(hit_digest_o),
    .hit_drop_o  (hit_drop_o),
    .hit_ack_i   (hit_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    HashState    st;
    HashState    ch;
    logic        nb;
    HashState    exp_d;
    logic [31:0] exp_n;
  } vec_t;

  vec_t        tbl [4];
  HashState    q_st [$];
  HashState    q_ch [$];
  logic        q_v  [$];
  logic        q_nb [$];
  logic [31:0] exp_q[$];
  logic        ack_en;
  logic [31:0] ack_nonce;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic drive(input HashState st, input HashState ch, input logic v, input logic nb);
    state_i    = st;
    chain_i    = ch;
    valid_i    = v;
    newblock_i = nb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input HashState st, input HashState ch, input logic v, input logic nb);
    q_st.push_back(st);
    q_ch.push_back(ch);
    q_v.push_back(v);
    q_nb.push_back(nb);
  endtask

  function automatic HashState mk(input logic [31:0] a, input logic [31:0] b);
    HashState s;
    s = '{a, b, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5};
    return s;
  endfunction

  // Back-to-back streaming; every valid_o is checked against the expected nonce queue.
  task automatic run_stream();
    int n;
    n = q_st.size();
    for (int c = 0; c < n + DEPTH + 1; c++) begin
      if (c < n) drive(q_st[c], q_ch[c], q_v[c], q_nb[c]);
      else       drive('0, '0, 1'b0, 1'b0);
      tick();
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream_extra: got valid_o nonce %h expected no output", nonce_o);
        end else begin
          chk("stream_nonce", nonce_o, exp_q.pop_front());
        end
      end
      hit_ack_i = ack_en && valid_o && (nonce_o == ack_nonce);
    end
    hit_ack_i = 1'b0;
    chk("stream_drained", exp_q.size(), 0);
    q_st.delete();
    q_ch.delete();
    q_v.delete();
    q_nb.delete();
    exp_q.delete();
  endtask

  HashState ones, twos, fs, hd;
  logic     no_valid_seen;

  initial begin
    rst = 1'b1;
    hit_ack_i = 1'b0;
    ack_en = 1'b0;
    ack_nonce = 32'd0;
    drive('0, '0, 1'b0, 1'b0);

    ones = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    twos = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
    fs   = '{8{32'hFFFFFFFF}};
    tbl[0] = '{'0, SHA256_IV, 1'b1, SHA256_IV, 32'd0};
    tbl[1] = '{fs, twos, 1'b0, ones, 32'd1};
    tbl[2] = '{'{32'h12345678, 32'h80000000, 32'hDEADBEEF, 32'h00000001,
                 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0F0F0F0F, 32'hAAAAAAAA},
               '{32'h11111111, 32'h80000000, 32'h21524111, 32'h00000002,
                 32'hFFFFFFFF, 32'h00000001, 32'hF0F0F0F0, 32'h55555555},
               1'b0,
               '{32'h23456789, 32'h00000000, 32'h00000000, 32'h00000003,
                 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
               32'd2};
    tbl[3] = '{'{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
               '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
               1'b1,
               '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12, 32'd14, 32'd16},
               32'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_hit_valid", hit_valid_o, 0);
    chk("rst_hit_drop", hit_drop_o, 0);
    chk("rst_hit_nonce", hit_nonce_o, 0);
    chk("rst_hit_digest", hit_digest_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-shot table: zero state, carry wrap, mixed carries, newblock restart
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].st, tbl[i].ch, 1'b1, tbl[i].nb);
      tick();
      drive('0, '0, 1'b0, 1'b0);
      for (int k = 1; k < DEPTH; k++) tick();
      chk($sformatf("vec%0d_valid", i), valid_o, 1);
      chk($sformatf("vec%0d_digest", i), digest_o, tbl[i].exp_d);
      chk($sformatf("vec%0d_nonce", i), nonce_o, tbl[i].exp_n);
      chk($sformatf("vec%0d_newblock", i), newblock_o, tbl[i].nb);
      tick();
      chk($sformatf("vec%0d_single_pulse", i), valid_o, 0);
    end
    chk("table_no_hit", hit_valid_o, 0);

    // Counter: 5 valids, bubble, 2 more, then a fresh newblock
    for (int i = 0; i < 5; i++) push(ones, ones, 1'b1, i == 0);
    push(ones, ones, 1'b0, 1'b0);
    push(ones, ones, 1'b1, 1'b0);
    push(ones, ones, 1'b1, 1'b0);
    push(ones, ones, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    run_stream();

    // Counter wrap
    force dut.count_reg = 32'hFFFFFFFF;
    #1;
    release dut.count_reg;
    push(ones, ones, 1'b1, 1'b0);
    push(ones, ones, 1'b1, 1'b0);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'd0);
    run_stream();

    // Hit capture: nonce1 has a=1 (just misses), nonce3 has a=0 (hit)
    push(mk(32'h80000000, 0), '0, 1'b1, 1'b1);
    push(mk(32'h00000001, 0), '0, 1'b1, 1'b0);
    push(mk(32'h80000000, 0), '0, 1'b1, 1'b0);
    push(mk(32'h00000000, 32'hFFFFFFFF), '0, 1'b1, 1'b0);
    push(mk(32'h80000000, 0), '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back(i);
    run_stream();
    chk("hit_valid", hit_valid_o, 1);
    chk("hit_nonce", hit_nonce_o, 3);
    hd = mk(32'h00000000, 32'hFFFFFFFF);
    chk("hit_digest", hit_digest_o, hd);
    chk("hit_no_drop_yet", hit_drop_o, 0);

    // Second hit without ack is dropped
    push(mk(32'h00000000, 32'h1), '0, 1'b1, 1'b0);
    exp_q.push_back(5);
    run_stream();
    chk("drop_keep_nonce", hit_nonce_o, 3);
    chk("drop_flag", hit_drop_o, 1);
    chk("drop_still_valid", hit_valid_o, 1);

    // Ack collision at nonce 9
    push(mk(32'h80000000, 0), '0, 1'b1, 1'b0);
    push(mk(32'h80000000, 0), '0, 1'b1, 1'b0);
    push(mk(32'h80000000, 0), '0, 1'b1, 1'b0);
    push(mk(32'h00000000, 32'h1234), '0, 1'b1, 1'b0);
    for (int i = 6; i < 10; i++) exp_q.push_back(i);
    ack_en = 1'b1;
    ack_nonce = 32'd9;
    run_stream();
    ack_en = 1'b0;
    chk("coll_nonce", hit_nonce_o, 9);
    chk("coll_valid", hit_valid_o, 1);
    hd = mk(32'h00000000, 32'h1234);
    chk("coll_digest", hit_digest_o, hd);
    chk("coll_drop_unchanged", hit_drop_o, 1);
    hit_ack_i = 1'b1;
    tick();
    hit_ack_i = 1'b0;
    chk("lone_ack_empty", hit_valid_o, 0);
    hit_ack_i = 1'b1;
    tick();
    hit_ack_i = 1'b0;
    chk("ack_while_empty", hit_valid_o, 0);

    // Reset mid-flight with a hit held
    push(mk(32'h00000000, 32'h0), '0, 1'b1, 1'b1);
    exp_q.push_back(0);
    run_stream();
    chk("pre_rst_hit_held", hit_valid_o, 1);
    drive(mk(32'h0, 32'h0), '0, 1'b1, 1'b0);
    tick();
    drive(mk(32'h0, 32'h0), '0, 1'b1, 1'b0);
    tick();
    drive('0, '0, 1'b0, 1'b0);
    chk("pre_rst_in_flight", valid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", valid_o, 0);
    chk("rst_async_hit_valid", hit_valid_o, 0);
    chk("rst_async_drop", hit_drop_o, 0);
    chk("rst_async_hit_nonce", hit_nonce_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    no_valid_seen = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      tick();
      if (valid_o) no_valid_seen = 1'b0;
    end
    chk("post_rst_no_pulse", no_valid_seen, 1);
    push(ones, ones, 1'b1, 1'b1);
    exp_q.push_back(0);
    run_stream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
